frame_rx: RTL

Byte-to-frame receiver between the UART receiver and the bus arbiter. Consumes the byte stream the UART receiver produces (one-cycle valid strobe plus byte), recognises a 3-byte frame (start byte, data byte, CRC byte), checks the CRC-8 of the data byte, and presents the data byte with a one-cycle `done` pulse. A wrong CRC raises `crc_error`; a stalled frame raises `con_error`; both feed the arbiter's error outputs.

---
 rtl/frame_pkg.sv | 14 +
 rtl/frame_rx_crc8.sv | 25 ++
 rtl/frame_rx.sv | 108 ++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// frame_rx shared types and constants.
// State encoding, default start byte and CRC polynomial.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        WAIT_CRC
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;
    localparam logic [7:0] CRC_POLY    = 8'h07;

endpackage

// File: rtl/frame_rx_crc8.sv
// CRC-8 over one byte: poly 0x07, init 0, MSB first.
// Pure combinational, eight unrolled shift/XOR steps.
module crc8
    import frame_pkg::*;
(
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = i_data;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[7]) begin
                w_acc = {w_acc[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_acc = {w_acc[6:0], 1'b0};
            end
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/frame_rx.sv
// Byte-to-frame receiver: SOF, data, CRC-8 of data.
// Emits done / crc_error / con_error one-cycle pulses.
module frame_rx
    import frame_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         TIMEOUT = 200000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic [7:0] readdata,
    output logic       done,
    output logic       crc_error,
    output logic       con_error
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic [7:0]       r_readdata;
    logic [7:0]       w_readdata_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_crc_err;
    logic             w_crc_err_nxt;
    logic             r_con_err;
    logic             w_con_err_nxt;
    logic [7:0]       w_crc;

    crc8 u_crc8 (
        .i_data (r_data),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_readdata <= '0;
            r_done     <= 1'b0;
            r_crc_err  <= 1'b0;
            r_con_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data     <= w_data_nxt;
            r_readdata <= w_readdata_nxt;
            r_done     <= w_done_nxt;
            r_crc_err  <= w_crc_err_nxt;
            r_con_err  <= w_con_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_data_nxt     = r_data;
        w_readdata_nxt = r_readdata;
        w_done_nxt     = 1'b0;
        w_crc_err_nxt  = 1'b0;
        w_con_err_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (byte_valid && byte_in == SOF) begin
                    w_state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA, WAIT_CRC: begin
                // An arriving byte always beats an expiring timeout.
                if (byte_valid) begin
                    if (r_state == WAIT_DATA) begin
                        w_data_nxt  = byte_in;
                        w_state_nxt = WAIT_CRC;
                    end else begin
                        if (byte_in == w_crc) begin
                            w_readdata_nxt = r_data;
                            w_done_nxt     = 1'b1;
                        end else begin
                            w_crc_err_nxt = 1'b1;
                        end
                        w_state_nxt = IDLE;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    w_con_err_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign readdata  = r_readdata;
    assign done      = r_done;
    assign crc_error = r_crc_err;
    assign con_error = r_con_err;

endmodule
